// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one edge-triggered SDRAM controller port between
// NPORTS level req/ack requesters, producing clean rd/we rising edges and
// returning read data with a one-cycle ack to the winning port.
module sdram_arbiter #(
  parameter int NPORTS       = 3,
  parameter int FIXED_PRIO   = 0,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    wr,
  input  logic [NPORTS*25-1:0] addr,
  input  logic [NPORTS*8-1:0]  wdata,
  output logic [NPORTS-1:0]    ack,
  output logic [7:0]           rdata,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic [24:0]          mem_addr,
  output logic [7:0]           mem_din,
  output logic                 mem_we,
  output logic                 mem_rd,
  input  logic [7:0]           mem_dout,
  input  logic                 mem_ready
);

  localparam int CW = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        rr_ptr, rr_ptr_nxt;
  logic [1:0]        grant_nxt;
  logic              busy_nxt;
  logic [24:0]       mem_addr_nxt;
  logic [7:0]        mem_din_nxt;
  logic              mem_we_nxt, mem_rd_nxt;
  logic [7:0]        rdata_nxt;
  logic [NPORTS-1:0] ack_nxt;
  logic              wr_q, wr_q_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [1:0]        start_ptr;
  logic              win_found;
  logic [1:0]        win_idx;

  // First requesting port at or after ptr, wrapping; returns {found, index}.
  // Scanning from the far end lets the nearest hit overwrite the others.
  function automatic logic [2:0] pick(input logic [NPORTS-1:0] r, input logic [1:0] ptr);
    logic       found;
    logic [1:0] idx;
    int         j;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NPORTS) j = j - NPORTS;
      if (r[j]) begin
        found = 1'b1;
        idx   = 2'(j);
      end
    end
    return {found, idx};
  endfunction

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    grant_nxt    = grant;
    busy_nxt     = busy;
    mem_addr_nxt = mem_addr;
    mem_din_nxt  = mem_din;
    mem_we_nxt   = mem_we;
    mem_rd_nxt   = mem_rd;
    rdata_nxt    = rdata;
    ack_nxt      = '0;
    wr_q_nxt     = wr_q;
    cnt_nxt      = cnt;
    start_ptr    = (FIXED_PRIO != 0) ? 2'd0 : rr_ptr;
    {win_found, win_idx} = pick(req, start_ptr);

    case (state)
      S_IDLE: begin
        // Hold off while the controller is not ready (e.g. still initialising).
        if (mem_ready && win_found) begin
          grant_nxt    = win_idx;
          mem_addr_nxt = addr[25*int'(win_idx) +: 25];
          mem_din_nxt  = wdata[8*int'(win_idx) +: 8];
          wr_q_nxt     = wr[win_idx];
          busy_nxt     = 1'b1;
          state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_rd_nxt = ~wr_q;
        mem_we_nxt = wr_q;
        cnt_nxt    = CW'(GUARD_CYCLES);
        state_nxt  = S_GUARD;
      end
      S_GUARD: begin
        // Controller drops ready one edge after seeing the strobe; ignore the stale ready.
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A same-word read hit never drops ready, so this sample may come right away.
        if (mem_ready) begin
          mem_rd_nxt = 1'b0;
          mem_we_nxt = 1'b0;
          ack_nxt    = NPORTS'(1) << grant;
          if (!wr_q) rdata_nxt = mem_dout;
          state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        busy_nxt = 1'b0;
        if (FIXED_PRIO == 0)
          rr_ptr_nxt = (int'(grant) >= NPORTS - 1) ? 2'd0 : grant + 2'd1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; reset drops strobes immediately with no ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      rr_ptr   <= 2'd0;
      grant    <= 2'd0;
      busy     <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      mem_rd   <= 1'b0;
      rdata    <= '0;
      ack      <= '0;
      wr_q     <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant    <= grant_nxt;
      busy     <= busy_nxt;
      mem_addr <= mem_addr_nxt;
      mem_din  <= mem_din_nxt;
      mem_we   <= mem_we_nxt;
      mem_rd   <= mem_rd_nxt;
      rdata    <= rdata_nxt;
      ack      <= ack_nxt;
      wr_q     <= wr_q_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: behavioural SDRAM controller model, scoreboard of
// expected acks, table of single transactions and hand-written corner sequences.
module tb_sdram_arbiter;
  localparam int NP = 3;
  localparam int GC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic [NP-1:0]   req = '0, wr = '0, req_f = '0;
  logic [NP*25-1:0] addr = '0;
  logic [NP*8-1:0]  wdata = '0;

  logic [NP-1:0] ack, ack_f;
  logic [7:0]    rdata, rdata_f, mem_dout, mem_din, mem_din_f;
  logic [1:0]    grant, grant_f;
  logic          busy, busy_f, mem_we, mem_rd, mem_we_f, mem_rd_f, mem_ready;
  logic [24:0]   mem_addr, mem_addr_f;

  sdram_arbiter #(.NPORTS(NP), .FIXED_PRIO(0), .GUARD_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .grant(grant), .busy(busy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_dout(mem_dout), .mem_ready(mem_ready));

  sdram_arbiter #(.NPORTS(NP), .FIXED_PRIO(1), .GUARD_CYCLES(GC)) dut_fix (
    .clk(clk), .reset(reset), .req(req_f), .wr(3'b000), .addr(addr), .wdata(wdata),
    .ack(ack_f), .rdata(rdata_f), .grant(grant_f), .busy(busy_f),
    .mem_addr(mem_addr_f), .mem_din(mem_din_f), .mem_we(mem_we_f), .mem_rd(mem_rd_f),
    .mem_dout(8'hC3), .mem_ready(1'b1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // ---------------- controller model ----------------
  function automatic logic [7:0] pat(input logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  logic [24:0] log_a [16];
  logic [7:0]  log_d [16];
  int          log_n = 0;

  function automatic logic [7:0] mem_read(input logic [24:0] a);
    logic [7:0] v;
    v = (a == 25'h10) ? 8'hA5 : pat(a);
    for (int i = 0; i < log_n; i++) if (log_a[i] == a) v = log_d[i];
    return v;
  endfunction

  logic        rdy = 1'b1, prev_rd = 1'b0, prev_we = 1'b0, pend_wr = 1'b0;
  logic [24:0] pend_addr = '0;
  logic [7:0]  pend_din = '0, dout_q = '0;
  int          dly = 0, rd_rises = 0, we_rises = 0, low_cnt = 0, last_low = 0;
  bit          hit_mode = 1'b0, startup = 1'b0;

  assign mem_ready = rdy & ~startup;
  assign mem_dout  = dout_q;

  always @(posedge clk) begin
    prev_rd <= mem_rd;
    prev_we <= mem_we;
    if ((mem_rd && !prev_rd) || (mem_we && !prev_we)) begin
      if (mem_rd && !prev_rd) rd_rises <= rd_rises + 1;
      else                    we_rises <= we_rises + 1;
      last_low <= low_cnt;
      low_cnt  <= 0;
      if (mem_rd && hit_mode) dout_q <= mem_read(mem_addr);
      else begin
        rdy       <= 1'b0;
        dly       <= 3;
        pend_wr   <= mem_we;
        pend_addr <= mem_addr;
        pend_din  <= mem_din;
      end
    end else begin
      if (!mem_rd && !mem_we) low_cnt <= low_cnt + 1;
      if (dly > 0) begin
        dly <= dly - 1;
        if (dly == 1) begin
          rdy <= 1'b1;
          if (pend_wr) begin
            log_a[log_n] <= pend_addr;
            log_d[log_n] <= pend_din;
            log_n        <= log_n + 1;
          end else dout_q <= mem_read(pend_addr);
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { int port; logic [7:0] rd; } exp_t;
  exp_t sbq[$];
  int   ack_count = 0;
  int   fix_acks  = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (ack != '0) begin
      if (sbq.size() == 0) check("unexpected_ack", 32'(ack), 32'd0);
      else begin
        e = sbq.pop_front();
        check("ack_port", 32'(ack), 32'd1 << e.port);
        check("grant", 32'(grant), 32'(e.port));
        check("rdata", 32'(rdata), 32'(e.rd));
      end
      ack_count <= ack_count + 1;
    end
    if (ack_f != '0) begin
      check("fix_ack", 32'(ack_f), 32'd1);
      check("fix_grant", 32'(grant_f), 32'd0);
      check("fix_out", 32'({rdata_f, busy_f, mem_rd_f, mem_we_f, mem_din_f}),
            32'({8'hC3, 1'b1, 1'b0, 1'b0, 8'h00}));
      check("fix_addr", 32'(mem_addr_f), 32'h100);
      fix_acks <= fix_acks + 1;
    end
  end

  task automatic push_exp(input int p, input logic [7:0] r);
    exp_t e;
    e.port = p;
    e.rd   = r;
    sbq.push_back(e);
  endtask

  // One request on port p; returns grant-to-ack latency and latched bus values.
  task automatic do_txn(input int p, input bit w, input logic [24:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, output int lat,
                        output logic [24:0] got_a, output logic [7:0] got_d);
    int t_b, t_a;
    push_exp(p, exp_rd);
    addr[25*p +: 25] = a;
    wdata[8*p +: 8]  = d;
    wr[p]  = w;
    req[p] = 1'b1;
    t_b = -1; t_a = -1;
    got_a = '0; got_d = '0;
    for (int i = 0; i < 200 && t_a < 0; i++) begin
      @(posedge clk); #1;
      if (busy && t_b < 0) t_b = i;
      if (ack[p]) begin
        t_a = i;
        got_a = mem_addr;
        got_d = mem_din;
      end
    end
    req[p] = 1'b0;
    check("txn_done", 32'(t_a >= 0), 32'd1);
    lat = (t_a >= 0) ? t_a - t_b : -1;
  endtask

  typedef struct { int port; bit w; logic [24:0] a; logic [7:0] d; logic [7:0] exp_rd; } vec_t;
  vec_t vt[8];

  initial begin
    int          lat, r0, w0;
    logic [24:0] ga;
    logic [7:0]  gd;

    vt[0] = '{1, 1'b0, 25'h0000010, 8'h00, 8'hA5};
    vt[1] = '{2, 1'b1, 25'h1FFFFFF, 8'h5C, 8'hA5};
    vt[2] = '{2, 1'b0, 25'h1FFFFFF, 8'h00, 8'h5C};
    vt[3] = '{0, 1'b0, 25'h0000123, 8'h00, 8'h78};
    vt[4] = '{1, 1'b1, 25'h0000123, 8'h99, 8'h78};
    vt[5] = '{1, 1'b0, 25'h0000123, 8'h00, 8'h99};
    vt[6] = '{0, 1'b0, 25'h00ABCDE, 8'h00, 8'h38};
    vt[7] = '{2, 1'b0, 25'h0000000, 8'h00, 8'h5A};

    // Reset held with all ports requesting: everything quiet.
    addr  = {25'h302, 25'h201, 25'h100};
    req   = 3'b111;
    req_f = 3'b111;
    repeat (4) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({mem_we, mem_rd}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_no_edges", 32'(rd_rises + we_rises), 32'd0);
    check("rst_fix_ack", 32'(ack_f), 32'd0);

    // Round-robin order 0,1,2,0,1,2 after release; fixed instance always 0.
    for (int k = 0; k < 6; k++) push_exp(k % 3, pat(addr[25*(k%3) +: 25]));
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 400 && ack_count < 6; i++) begin
      @(posedge clk); #1;
    end
    req   = '0;
    req_f = '0;
    check("rr_acks", 32'(ack_count), 32'd6);
    check("rr_rd_rises", 32'(rd_rises), 32'd6);
    check("fix_acks_min", 32'(fix_acks >= 3), 32'd1);
    repeat (10) @(posedge clk);
    #1;

    // No grant while the controller holds ready low.
    startup = 1'b1;
    r0 = rd_rises;
    fork
      do_txn(0, 1'b0, 25'h300, 8'h00, 8'h59, lat, ga, gd);
      begin
        repeat (6) @(posedge clk);
        #1;
        check("startup_busy", 32'(busy), 32'd0);
        check("startup_no_rd", 32'(rd_rises - r0), 32'd0);
        startup = 1'b0;
      end
    join

    // Table of single transactions.
    for (int i = 0; i < 8; i++) begin
      r0 = rd_rises;
      w0 = we_rises;
      do_txn(vt[i].port, vt[i].w, vt[i].a, vt[i].d, vt[i].exp_rd, lat, ga, gd);
      check("vec_lat_min", 32'(lat >= GC + 2), 32'd1);
      check("vec_rd_edge", 32'(rd_rises - r0), 32'(!vt[i].w));
      check("vec_we_edge", 32'(we_rises - w0), 32'(vt[i].w));
      check("vec_mem_addr", 32'(ga), 32'(vt[i].a));
      if (vt[i].w) check("vec_mem_din", 32'(gd), 32'(vt[i].d));
    end

    // Read then same-word hit with ready never dropping.
    do_txn(0, 1'b0, 25'h20, 8'h00, 8'h7A, lat, ga, gd);
    hit_mode = 1'b1;
    r0 = rd_rises;
    do_txn(0, 1'b0, 25'h21, 8'h00, 8'h7B, lat, ga, gd);
    check("hit_latency", 32'(lat), 32'(GC + 2));
    check("hit_rd_edge", 32'(rd_rises - r0), 32'd1);
    check("hit_gap", 32'(last_low >= 2), 32'd1);
    hit_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset while waiting on ready: strobe drops at once, no ack, retry works.
    addr[25 +: 25] = 25'h10;
    wr[1]  = 1'b0;
    req[1] = 1'b1;
    for (int i = 0; i < 50 && !mem_rd; i++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("wait_rd_high", 32'(mem_rd), 32'd1);
    reset = 1'b1;
    #1;
    check("async_rd_drop", 32'(mem_rd), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_rdata", 32'(rdata), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("reset_no_ack", 32'(ack), 32'd0);
    @(negedge clk) reset = 1'b0;
    do_txn(1, 1'b0, 25'h10, 8'h00, 8'hA5, lat, ga, gd);
    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
